// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port word memory between the instruction-fetch port (I)
// and the load/store port (D). Each granted access holds the memory controls
// for WAIT_CYC cycles. Read data is registered, and a one-cycle ack pulse
// marks the end of each access. On a tie the port that was not served last
// wins, so neither port waits behind more than one foreign access.
//
// Ports:
//   clock, reset                 system clock, async active-high reset
//   i_req, i_addr                instruction read request and address
//   i_rdata, i_ack               registered instruction data, completion pulse
//   d_req, d_we, d_addr, d_wdata data request (we=1 write, 0 read)
//   d_rdata, d_ack               registered data read value, completion pulse
//   mem_ren, mem_wen             memory read/write enables (never both high)
//   mem_addr, mem_din            memory address and write data
//   mem_dout                     combinational read data from the memory
module mem_port_arbiter #(
  parameter int WAIT_CYC = 2,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ack,
  output logic          mem_ren,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  localparam logic       LAST_I   = 1'b0;
  localparam logic       LAST_D   = 1'b1;
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last;

  // Main FSM: grants in IDLE, counts down the wait cycles in a grant state,
  // then captures read data and pulses the owning port's ack. The acks
  // default low every cycle, so each one is high for exactly one cycle.
  // A D tie goes to D unless D was the last port served.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      last    <= LAST_I;
      i_ack   <= 1'b0;
      d_ack   <= 1'b0;
      i_rdata <= '0;
      d_rdata <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (d_req && (!i_req || last == LAST_I)) begin
            state <= GNT_D;
            cnt   <= CNT_LOAD;
            last  <= LAST_D;
          end else if (i_req) begin
            state <= GNT_I;
            cnt   <= CNT_LOAD;
            last  <= LAST_I;
          end
        end
        GNT_I: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            i_rdata <= mem_dout;
            i_ack   <= 1'b1;
            state   <= IDLE;
          end
        end
        GNT_D: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // A write leaves the previously returned read data in place.
            if (!d_we) d_rdata <= mem_dout;
            d_ack <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory controls come from the state register alone, so a request that
  // has not been granted never reaches the memory, and an async reset drops
  // the enables immediately. Only GNT_D can raise wen, and it lowers ren
  // whenever it does, so the two enables can never overlap.
  always_comb begin
    mem_ren  = 1'b0;
    mem_wen  = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    case (state)
      GNT_I: begin
        mem_ren  = 1'b1;
        mem_addr = i_addr;
      end
      GNT_D: begin
        mem_ren  = ~d_we;
        mem_wen  = d_we;
        mem_addr = d_addr;
        mem_din  = d_we ? d_wdata : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. The main instance uses WAIT_CYC=2 and
// is backed by a small writable memory model. A second instance uses
// WAIT_CYC=1 and is backed by a fixed ROM. Outputs are sampled 1ns after
// each rising edge.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        memInit = 1'b1;

  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ack;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  logic        wIReq = 1'b0;
  logic [31:0] wIAddr = '0;
  logic [31:0] wIRdata;
  logic        wIAck;
  logic [31:0] wDRdata;
  logic        wDAck;
  logic        wMemRen;
  logic        wMemWen;
  logic [31:0] wMemAddr;
  logic [31:0] wMemDin;
  logic [31:0] wMemDout;

  logic [31:0] mem [0:15];

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.WAIT_CYC(2), .AW(32), .DW(32)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout)
  );

  mem_port_arbiter #(.WAIT_CYC(1), .AW(32), .DW(32)) dut1 (
    .clock(clock), .reset(reset),
    .i_req(wIReq), .i_addr(wIAddr), .i_rdata(wIRdata), .i_ack(wIAck),
    .d_req(1'b0), .d_we(1'b0), .d_addr(32'd0), .d_wdata(32'd0),
    .d_rdata(wDRdata), .d_ack(wDAck),
    .mem_ren(wMemRen), .mem_wen(wMemWen), .mem_addr(wMemAddr),
    .mem_din(wMemDin), .mem_dout(wMemDout)
  );

  // Writable memory model: preload while memInit is high, otherwise accept
  // writes on the rising edge. Reads are combinational.
  always @(posedge clock) begin
    if (memInit) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'd0;
      mem[5] <= 32'h0000_1234;
    end else if (mem_wen) begin
      mem[mem_addr[3:0]] <= mem_din;
    end
  end
  assign mem_dout = mem[mem_addr[3:0]];

  function automatic logic [31:0] romRead(input logic [31:0] a);
    case (a)
      32'd0:   return 32'h0000_0100;
      32'd1:   return 32'h0000_0111;
      32'd2:   return 32'h0000_0222;
      default: return 32'h0000_0000;
    endcase
  endfunction
  assign wMemDout = romRead(wMemAddr);

  // The read and write enables must never be high together on either instance.
  always @(negedge clock) begin
    checks++;
    if ((mem_ren && mem_wen) || (wMemRen && wMemWen)) begin
      failures++;
      $display("[TB] FAIL ren_wen_exclusive: got ren=%b wen=%b ren1=%b wen1=%b required never both 1",
               mem_ren, mem_wen, wMemRen, wMemWen);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({i_ack, d_ack, mem_ren, mem_wen} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got ack/ren/wen=%b required 0000", {i_ack, d_ack, mem_ren, mem_wen});
    end
    checks++;
    if ({i_rdata, d_rdata, mem_addr, mem_din} !== 128'd0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h %h %h %h required all zero", i_rdata, d_rdata, mem_addr, mem_din);
    end
    checks++;
    if ({wIAck, wDAck, wMemRen, wMemWen, wIRdata, wDRdata} !== 68'd0) begin
      failures++;
      $display("[TB] FAIL reset_dut1: got %b %b %b %b %h %h required all zero",
               wIAck, wDAck, wMemRen, wMemWen, wIRdata, wDRdata);
    end
    memInit = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_i_read();
    i_req = 1'b1;
    i_addr = 32'd5;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (mem_ren !== (k <= 2) || mem_wen !== 1'b0) begin
        failures++;
        $display("[TB] FAIL iread_ren k=%0d: got ren=%b wen=%b required ren=%b wen=0", k, mem_ren, mem_wen, k <= 2);
      end
      checks++;
      if (i_ack !== (k == 3) || d_ack !== 1'b0) begin
        failures++;
        $display("[TB] FAIL iread_ack k=%0d: got i_ack=%b d_ack=%b required i_ack=%b d_ack=0", k, i_ack, d_ack, k == 3);
      end
      if (k == 1) begin
        checks++;
        if (mem_addr !== 32'd5) begin
          failures++;
          $display("[TB] FAIL iread_addr: got %h required 5", mem_addr);
        end
      end
      if (k == 3) begin
        checks++;
        if (i_rdata !== 32'h0000_1234) begin
          failures++;
          $display("[TB] FAIL iread_data: got %h required 00001234", i_rdata);
        end
        i_req = 1'b0;
      end
    end
  endtask

  task automatic test_d_write_read();
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'd8;
    d_wdata = 32'hDEAD_BEEF;
    for (int k = 1; k <= 2; k++) begin
      step();
      checks++;
      if (mem_wen !== 1'b1 || mem_ren !== 1'b0 || mem_din !== 32'hDEAD_BEEF || mem_addr !== 32'd8) begin
        failures++;
        $display("[TB] FAIL dwrite_ctrl k=%0d: got wen=%b ren=%b din=%h addr=%h required 1 0 deadbeef 8",
                 k, mem_wen, mem_ren, mem_din, mem_addr);
      end
    end
    step();
    checks++;
    if (d_ack !== 1'b1 || mem_wen !== 1'b0 || d_rdata !== 32'd0) begin
      failures++;
      $display("[TB] FAIL dwrite_ack: got ack=%b wen=%b rdata=%h required 1 0 00000000", d_ack, mem_wen, d_rdata);
    end
    d_we = 1'b0;
    d_wdata = 32'd0;
    step();
    checks++;
    if (mem_ren !== 1'b1 || mem_wen !== 1'b0 || mem_din !== 32'd0 || d_ack !== 1'b0) begin
      failures++;
      $display("[TB] FAIL dread_ctrl: got ren=%b wen=%b din=%h ack=%b required 1 0 0 0", mem_ren, mem_wen, mem_din, d_ack);
    end
    step();
    step();
    checks++;
    if (d_ack !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL dread_data: got ack=%b rdata=%h required 1 deadbeef", d_ack, d_rdata);
    end
    d_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    reset = 1'b1;
    i_req = 1'b1;
    i_addr = 32'd5;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'd8;
    step();
    reset = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (d_ack !== (k == 3 || k == 9) || i_ack !== (k == 6 || k == 12)) begin
        failures++;
        $display("[TB] FAIL b2b_order k=%0d: got d_ack=%b i_ack=%b required d_ack=%b i_ack=%b",
                 k, d_ack, i_ack, (k == 3 || k == 9), (k == 6 || k == 12));
      end
      if (k == 1 || k == 4) begin
        checks++;
        if (mem_addr !== (k == 1 ? 32'd8 : 32'd5)) begin
          failures++;
          $display("[TB] FAIL b2b_grant k=%0d: got addr=%h required %h", k, mem_addr, (k == 1 ? 32'd8 : 32'd5));
        end
      end
      if (k == 6) begin
        checks++;
        if (d_rdata !== 32'hDEAD_BEEF || i_rdata !== 32'h0000_1234) begin
          failures++;
          $display("[TB] FAIL b2b_data: got d=%h i=%h required deadbeef 00001234", d_rdata, i_rdata);
        end
      end
    end
    i_req = 1'b0;
    d_req = 1'b0;
    step();
    checks++;
    if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin
      failures++;
      $display("[TB] FAIL b2b_idle: got ren=%b wen=%b required 0 0", mem_ren, mem_wen);
    end
  endtask

  task automatic test_d_drop();
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'd5;
    step();
    d_req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) step();
      checks++;
      if (mem_ren !== (k <= 2) || d_ack !== (k == 3) || i_ack !== 1'b0) begin
        failures++;
        $display("[TB] FAIL ddrop k=%0d: got ren=%b d_ack=%b i_ack=%b required %b %b 0",
                 k, mem_ren, d_ack, i_ack, k <= 2, k == 3);
      end
      if (k == 3) begin
        checks++;
        if (d_rdata !== 32'h0000_1234) begin
          failures++;
          $display("[TB] FAIL ddrop_data: got %h required 00001234", d_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid_d();
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 32'd9;
    d_wdata = 32'hCAFE_F00D;
    step();
    checks++;
    if (mem_wen !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_pre: got wen=%b required 1", mem_wen);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (mem_wen !== 1'b0 || d_ack !== 1'b0 || mem_addr !== 32'd0 || mem_din !== 32'd0) begin
      failures++;
      $display("[TB] FAIL rstmid_drop: got wen=%b ack=%b addr=%h din=%h required 0 0 0 0",
               mem_wen, d_ack, mem_addr, mem_din);
    end
    step();
    checks++;
    if (d_ack !== 1'b0 || d_rdata !== 32'd0 || i_rdata !== 32'd0) begin
      failures++;
      $display("[TB] FAIL rstmid_hold: got ack=%b d_rdata=%h i_rdata=%h required 0 0 0", d_ack, d_rdata, i_rdata);
    end
    i_req = 1'b1;
    i_addr = 32'd5;
    d_we = 1'b0;
    d_addr = 32'd8;
    d_wdata = 32'd0;
    reset = 1'b0;
    step();
    checks++;
    if (mem_ren !== 1'b1 || mem_addr !== 32'd8) begin
      failures++;
      $display("[TB] FAIL rstmid_tie: got ren=%b addr=%h required 1 00000008", mem_ren, mem_addr);
    end
    step();
    step();
    checks++;
    if (d_ack !== 1'b1 || i_ack !== 1'b0 || d_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("[TB] FAIL rstmid_ack: got d_ack=%b i_ack=%b rdata=%h required 1 0 deadbeef", d_ack, i_ack, d_rdata);
    end
    d_req = 1'b0;
    i_req = 1'b0;
    step();
  endtask

  task automatic test_wait1();
    logic [31:0] expData [0:2];
    expData[0] = 32'h0000_0100;
    expData[1] = 32'h0000_0111;
    expData[2] = 32'h0000_0222;
    wIReq = 1'b1;
    for (int a = 0; a < 3; a++) begin
      wIAddr = 32'(a);
      step();
      checks++;
      if (wMemRen !== 1'b1 || wMemAddr !== 32'(a) || wIAck !== 1'b0) begin
        failures++;
        $display("[TB] FAIL wait1_grant a=%0d: got ren=%b addr=%h ack=%b required 1 %h 0", a, wMemRen, wMemAddr, wIAck, a);
      end
      step();
      checks++;
      if (wIAck !== 1'b1 || wIRdata !== expData[a] || wMemRen !== 1'b0) begin
        failures++;
        $display("[TB] FAIL wait1_ack a=%0d: got ack=%b rdata=%h ren=%b required 1 %h 0",
                 a, wIAck, wIRdata, wMemRen, expData[a]);
      end
    end
    wIReq = 1'b0;
    step();
    checks++;
    if (wIAck !== 1'b0 || wMemRen !== 1'b0 || wMemWen !== 1'b0 || wMemDin !== 32'd0 || wDAck !== 1'b0) begin
      failures++;
      $display("[TB] FAIL wait1_idle: got ack=%b ren=%b wen=%b din=%h dack=%b required all zero",
               wIAck, wMemRen, wMemWen, wMemDin, wDAck);
    end
  endtask

  // Scenarios run in order; each leaves both instances idle for the next.
  initial begin
    test_reset();
    test_i_read();
    test_d_write_read();
    test_back_to_back();
    test_d_drop();
    test_reset_mid_d();
    test_wait1();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single-port word memory between two requesters: an instruction-fetch port (I) and a load/store port (D).
- Sequences the memory's ren/wen/addr/din controls for each access and holds them for a configurable number of wait cycles.
- Returns registered read data with a one-cycle ack pulse.
- Sits between the core's fetch/memory stages and the memory block. Guarantees ren and wen are never active together.

Parameters:
- WAIT_CYC, 2, cycles each access holds the memory controls (legal 1..15).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- i_req  input  1  instruction-port read request.
- i_addr  input  AW  instruction read address.
- i_rdata  output  DW  registered instruction read data.
- i_ack  output  1  one-cycle pulse: I access complete.
- d_req  input  1  data-port request.
- d_we  input  1  data-port access type: 1 = write, 0 = read.
- d_addr  input  AW  data address.
- d_wdata  input  DW  data write value.
- d_rdata  output  DW  registered data read data.
- d_ack  output  1  one-cycle pulse: D access complete.
- mem_ren  output  1  memory read enable.
- mem_wen  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_din  output  DW  memory write data.
- mem_dout  input  DW  memory read data (combinational from memory).

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, cnt=0, last=I, i_ack=d_ack=0, i_rdata=d_rdata=0. Memory controls follow from IDLE, so mem_ren=mem_wen=0 and mem_addr=mem_din=0. A reset mid-access aborts it with no ack; the memory write may already have occurred.
- States: IDLE, GNT_I, GNT_D.
- IDLE transitions:
  - Only i_req=1: go to GNT_I.
  - Only d_req=1: go to GNT_D.
  - Both requesting: grant the port not in `last` (round-robin), so D wins the first tie after reset.
  - On every grant, load cnt=WAIT_CYC-1 and update `last` to the granted port.
- GNT_I memory controls: mem_ren=1, mem_wen=0, mem_addr=i_addr.
- GNT_D memory controls: mem_addr=d_addr; mem_ren=~d_we, mem_wen=d_we, mem_din=d_wdata (mem_din=0 for reads).
- Memory controls are decoded from the state register only, never from the raw req inputs. mem_ren and mem_wen are mutually exclusive in every state.
- Counting in a GNT state:
  - cnt>0: decrement cnt and stay.
  - cnt==0: capture mem_dout into the granted port's rdata on a read (rdata is untouched on a write), set that port's ack=1 for exactly one cycle, and go to IDLE.
- Latency: request seen at edge n → grant from edge n → ack high during the cycle after edge n+WAIT_CYC, with rdata valid in the same cycle. Each access occupies WAIT_CYC grant cycles plus one IDLE cycle, so back-to-back throughput is one access per WAIT_CYC+1 cycles.
- Requester obligations: hold req, addr, we and wdata stable until ack. If req drops mid-grant the access still completes and acks. A requester that wants no further access must drop req in its ack cycle; req still high in IDLE is treated as a new request.
- The ungranted requester waits with ack=0. Round-robin guarantees it the next grant, so no port waits for more than one foreign access.
- The module performs no address range checking; addresses pass through unchanged.

Test Plan:
- Reset then i_req=1, i_addr=5, mem_dout=0x1234 → mem_ren=1 for 2 cycles, i_ack pulses 1 cycle at edge 3, i_rdata=0x1234, d_ack stays 0.
- d_req=1, d_we=1, d_addr=8, d_wdata=0xDEADBEEF → mem_wen=1 and mem_ren=0 for 2 cycles, mem_din=0xDEADBEEF; the following D read of address 8 returns 0xDEADBEEF with d_ack.
- i_req and d_req both held high from reset → grant order D, I, D, I; each ack spaced 3 cycles apart; mem_ren&mem_wen==0 on every cycle (assertion).
- d_req dropped one cycle after grant → access still completes, d_ack pulses once, FSM returns to IDLE with no second grant.
- reset asserted asynchronously mid-GNT_D (between edges) → mem_wen and d_ack drop immediately, no ack issued, first access after release is granted to D on a tie.
- WAIT_CYC=1 build with back-to-back I reads of addresses 0,1,2 → one ack every 2 cycles, i_rdata tracks mem_dout captured in each grant cycle.
